// File: rtl/pulse_activity_monitor_if.sv
// Snapshot bus of pulse_activity_monitor: one valid/ready transfer carries the
// edge counts of every channel for one completed window plus its sequence number.
interface pulse_activity_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
);
    logic                    snap_valid;
    logic                    snap_ready;
    logic [NUM_CH*CNT_W-1:0] snap_counts;
    logic [7:0]              snap_index;

    modport master (
        output snap_valid,
        output snap_counts,
        output snap_index,
        input  snap_ready
    );

    modport slave (
        input  snap_valid,
        input  snap_counts,
        input  snap_index,
        output snap_ready
    );
endinterface

// File: rtl/pulse_activity_monitor.sv
// Counts rising edges per pulse channel over fixed windows of enabled cycles and
// publishes a snapshot of all counts at each window end over a valid/ready bus.
module pulse_activity_monitor #(
    parameter int NUM_CH = 4,
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        pulse_in,
    pulse_activity_monitor_if.master snap,
    output logic                     overrun
);
    localparam int               WIN_W    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic [NUM_CH-1:0]       prev_pulse;
    logic [NUM_CH-1:0]       edge_hit;
    logic [CNT_W-1:0]        acc     [NUM_CH];
    logic [CNT_W-1:0]        acc_sum [NUM_CH];
    logic [NUM_CH*CNT_W-1:0] final_counts;
    logic [WIN_W-1:0]        win_cnt;
    logic [7:0]              next_index;

    logic                    counting;
    logic                    window_end;
    logic                    accept;
    logic                    load;
    logic                    drop;

    logic                    snap_valid_q;
    logic [NUM_CH*CNT_W-1:0] snap_counts_q;
    logic [7:0]              snap_index_q;
    logic                    overrun_q;

    // ------------------------------------------------------------------
    // FSM state register and edge-detect history
    // ------------------------------------------------------------------
    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prev_pulse <= '0;
        end else begin
            state      <= state_nxt;
            prev_pulse <= pulse_in;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and per-cycle control decisions
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        counting   = 1'b0;
        window_end = 1'b0;
        accept     = 1'b0;
        load       = 1'b0;
        drop       = 1'b0;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else begin
                    counting = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        window_end = counting && (win_cnt == WIN_LAST);
        accept     = snap_valid_q && snap.snap_ready;
        // A finished window either replaces a free/departing snapshot or is lost.
        load       = window_end && (!snap_valid_q || snap.snap_ready);
        drop       = window_end && snap_valid_q && !snap.snap_ready;
    end

    // ------------------------------------------------------------------
    // Edge detection and saturating accumulation
    // ------------------------------------------------------------------
    assign edge_hit = pulse_in & ~prev_pulse;

    always_comb begin
        final_counts = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            acc_sum[i] = acc[i];
            if (edge_hit[i] && (acc[i] != CNT_MAX)) begin
                acc_sum[i] = acc[i] + CNT_W'(1);
            end
            final_counts[i*CNT_W +: CNT_W] = acc_sum[i];
        end
    end

    // NOTE: the accumulator array is a handful of flops rather than a RAM, so
    // it is reset like any other register; a true memory would not be.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
            end
        end else if (counting && !window_end) begin
            win_cnt <= win_cnt + WIN_W'(1);
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= acc_sum[i];
            end
        end else begin
            // Window end, idle, or leaving RUN: the next window starts from zero.
            win_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Snapshot register, sequence numbering and overrun flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_valid_q  <= 1'b0;
            snap_counts_q <= '0;
            snap_index_q  <= '0;
            next_index    <= '0;
            overrun_q     <= 1'b0;
        end else begin
            // Dropped windows still consume a number so the gap is visible downstream.
            if (window_end) begin
                next_index <= next_index + 8'd1;
            end

            if (load) begin
                snap_valid_q  <= 1'b1;
                snap_counts_q <= final_counts;
                snap_index_q  <= next_index;
            end else if (accept) begin
                snap_valid_q  <= 1'b0;
            end

            if (drop) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign snap.snap_valid  = snap_valid_q;
    assign snap.snap_counts = snap_counts_q;
    assign snap.snap_index  = snap_index_q;
    assign overrun          = overrun_q;

endmodule
